// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Packages : rv32i_mux_types, rv32i_types
// Brief    : Shared types for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv32i_mux_types;
  typedef enum logic [0:0] {
    pc_plus4 = 1'b0,
    alu_out  = 1'b1
  } pcmux_sel_t;
endpackage

package rv32i_types;
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_packet_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// Module   : fetch_skid_buffer
// Brief    : One-entry {pc, instr} holding register with load/unload/clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear || i_unload) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : PC owner and imem requester; squashes stale fetches on redirect.
//            Optional counters enabled by FETCH_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import rv32i_types::*;
  import rv32i_mux_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  pcmux_sel_t  pcmux_sel,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_squash_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_kill;
  logic [31:0]  r_kill_addr;
  if_packet_t   r_if;

  logic         w_redirect;
  logic         w_in_fetch;
  logic         w_resp_live;
  logic         w_skid_load;
  logic         w_skid_unload;
  logic         w_skid_valid;
  logic [31:0]  w_skid_pc;
  logic [31:0]  w_skid_instr;

  assign w_redirect  = (pcmux_sel == alu_out);
  assign w_in_fetch  = (r_state == FETCH);
  assign w_resp_live = w_in_fetch & imem_resp & ~r_kill;

  // A squashed request keeps presenting its original address until it completes.
  assign imem_read    = w_in_fetch;
  assign imem_address = r_kill ? r_kill_addr : r_pc;
  assign fetch_busy   = imem_read & ~imem_resp;

  assign w_skid_load   = w_resp_live & stall & r_if.valid & ~w_redirect;
  assign w_skid_unload = ~w_in_fetch & ~stall & ~w_redirect;

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_redirect),
    .i_pc     (r_pc),
    .i_instr  (imem_rdata),
    .o_valid  (w_skid_valid),
    .o_pc     (w_skid_pc),
    .o_instr  (w_skid_instr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_kill      <= 1'b0;
      r_kill_addr <= '0;
      r_if        <= '0;
    end else if (w_redirect) begin
      r_pc       <= br_target;
      r_if.valid <= 1'b0;
      r_state    <= FETCH;
      if (w_in_fetch && !imem_resp) begin
        r_kill      <= 1'b1;
        r_kill_addr <= imem_address;
      end else begin
        r_kill <= 1'b0;
      end
    end else if (w_in_fetch && imem_resp) begin
      if (r_kill) begin
        r_kill <= 1'b0;
        if (!stall) r_if.valid <= 1'b0;
      end else begin
        r_pc <= pc_next(r_pc);
        if (!stall || !r_if.valid) begin
          r_if <= '{valid: 1'b1, pc: r_pc, instr: imem_rdata};
        end else begin
          r_state <= HOLD;
        end
      end
    end else if (!w_in_fetch && !stall) begin
      r_if    <= '{valid: w_skid_valid, pc: w_skid_pc, instr: w_skid_instr};
      r_state <= FETCH;
    end else if (!stall) begin
      r_if.valid <= 1'b0;
    end
  end

  assign if_valid = r_if.valid;
  assign if_pc    = r_if.pc;
  assign if_instr = r_if.instr;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_squash;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch  <= '0;
      r_perf_squash <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_resp_live && !w_redirect)                    r_perf_fetch  <= r_perf_fetch + 32'd1;
      if (w_in_fetch && imem_resp && (r_kill || w_redirect)) r_perf_squash <= r_perf_squash + 32'd1;
      if (fetch_busy)                                    r_perf_stall  <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt  = r_perf_fetch;
  assign perf_squash_cnt = r_perf_squash;
  assign perf_stall_cnt  = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit with a latency-programmable
//            memory model and an in-order delivery scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
  import rv32i_mux_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  pcmux_sel_t  pcmux_sel = pc_plus4;
  logic [31:0] br_target = '0;
  logic        stall = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  logic        mon_en = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .pcmux_sel    (pcmux_sel),
    .br_target    (br_target),
    .stall        (stall),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .fetch_busy   (fetch_busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_squash_cnt (perf_squash_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: responds after lat cycles of a held request.
  always @(negedge clk) begin
    if (!rst) begin
      imem_resp = 1'b0;
      wait_cnt  = 0;
    end else if (imem_read) begin
      if (wait_cnt + 1 >= lat) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_data(imem_address);
        wait_cnt   = 0;
      end else begin
        imem_resp = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      imem_resp = 1'b0;
      wait_cnt  = 0;
    end
  end

  // An instruction is consumed when IF/ID is valid and not stalled at the next edge.
  always @(negedge clk) begin
    if (mon_en && if_valid && !stall) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL sb_unexpected got pc=%h instr=%h expected none", if_pc, if_instr);
      end else begin
        exp_pc = sb.pop_front();
        if (if_pc !== exp_pc || if_instr !== mem_data(exp_pc)) begin
          failures = failures + 1;
          $display("FAIL sb_delivery got pc=%h instr=%h expected pc=%h instr=%h",
                   if_pc, if_instr, exp_pc, mem_data(exp_pc));
        end
      end
    end
  end

  task automatic tick_neg;
    @(negedge clk); #1;
  endtask

  task automatic tick_pos;
    @(posedge clk); #2;
  endtask

  task automatic apply_reset(input int l, input logic st);
    rst = 1'b0;
    mon_en = 1'b0;
    stall = st;
    pcmux_sel = pc_plus4;
    br_target = '0;
    sb.delete();
    lat = l;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic release_reset;
    @(posedge clk); #2;
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick_pos();
      n++;
    end
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s_drain got %0d pending expected 0", name, sb.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  task automatic test_reset;
    apply_reset(1, 1'b0);
    tick_neg();
    if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b expected 0", if_valid); end
    checks++;
    if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got %h expected 0", if_pc); end
    checks++;
    if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got %h expected 0", if_instr); end
    checks++;
    if (imem_read !== 1'b1) begin failures++; $display("FAIL rst_read got %b expected 1", imem_read); end
    checks++;
    if (imem_address !== 32'h60) begin failures++; $display("FAIL rst_addr got %h expected 60", imem_address); end
    checks++;
    if (fetch_busy !== 1'b1) begin failures++; $display("FAIL rst_busy got %b expected 1", fetch_busy); end
    checks++;
  endtask

  task automatic test_zero_wait;
    apply_reset(1, 1'b0);
    for (int i = 0; i < 4; i++) sb.push_back(32'h60 + 32'(4 * i));
    release_reset();
    tick_neg();
    chk("zw_first_bubble", {31'b0, if_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick_neg();
      chk("zw_valid", {31'b0, if_valid}, 32'd1);
      chk("zw_pc", if_pc, 32'h60 + 32'(4 * i));
    end
    drain("zw");
  endtask

  task automatic test_latency;
    apply_reset(3, 1'b0);
    sb.push_back(32'h60);
    release_reset();
    for (int i = 0; i < 3; i++) begin
      tick_neg();
      chk("lat_addr", imem_address, 32'h60);
      chk("lat_busy", {31'b0, fetch_busy}, (i < 2) ? 32'd1 : 32'd0);
    end
    tick_neg();
    chk("lat_instr", if_instr, mem_data(32'h60));
    chk("lat_next_addr", imem_address, 32'h64);
    drain("lat");
  endtask

  task automatic test_redirect;
    apply_reset(3, 1'b0);
    sb.push_back(32'h60);
    sb.push_back(32'h200);
    release_reset();
    repeat (3) tick_neg();
    tick_pos();
    pcmux_sel = alu_out;
    br_target = 32'h200;
    tick_neg();
    chk("rd_pending_addr", imem_address, 32'h64);
    chk("rd_pending_resp", {31'b0, imem_resp}, 32'd0);
    tick_pos();
    pcmux_sel = pc_plus4;
    br_target = '0;
    for (int i = 0; i < 2; i++) begin
      tick_neg();
      chk("rd_old_addr", imem_address, 32'h64);
      chk("rd_squash_valid", {31'b0, if_valid}, 32'd0);
    end
    tick_neg();
    chk("rd_new_addr", imem_address, 32'h200);
    chk("rd_after_valid", {31'b0, if_valid}, 32'd0);
    drain("rd");
`ifdef FETCH_PERF_EN
    chk("rd_perf_squash", perf_squash_cnt, 32'd1);
`endif
  endtask

  task automatic test_stall;
    apply_reset(1, 1'b1);
    sb.push_back(32'h60);
    sb.push_back(32'h64);
    sb.push_back(32'h68);
    release_reset();
    tick_neg();
    tick_neg();
    chk("st_pc_first", if_pc, 32'h60);
    chk("st_valid_first", {31'b0, if_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick_neg();
      chk("st_hold_read", {31'b0, imem_read}, 32'd0);
      chk("st_hold_pc", if_pc, 32'h60);
    end
    tick_pos();
    stall = 1'b0;
    tick_neg();
    chk("st_release_pc", if_pc, 32'h60);
    tick_neg();
    chk("st_skid_pc", if_pc, 32'h64);
    tick_neg();
    chk("st_next_pc", if_pc, 32'h68);
    drain("st");
  endtask

  task automatic test_redirect_resp_stall;
    apply_reset(1, 1'b0);
    sb.push_back(32'h300);
    release_reset();
    tick_neg();
    tick_pos();
    stall = 1'b1;
    pcmux_sel = alu_out;
    br_target = 32'h300;
    tick_neg();
    chk("rrs_resp", {31'b0, imem_resp}, 32'd1);
    tick_pos();
    stall = 1'b0;
    pcmux_sel = pc_plus4;
    tick_neg();
    chk("rrs_valid", {31'b0, if_valid}, 32'd0);
    chk("rrs_addr", imem_address, 32'h300);
    tick_neg();
    chk("rrs_pc", if_pc, 32'h300);
`ifdef FETCH_PERF_EN
    chk("rrs_perf_squash", perf_squash_cnt, 32'd1);
`endif
    drain("rrs");
  endtask

  task automatic test_wrap;
    apply_reset(1, 1'b0);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    release_reset();
    pcmux_sel = alu_out;
    br_target = 32'hFFFF_FFFC;
    tick_pos();
    pcmux_sel = pc_plus4;
    tick_neg();
    chk("wrap_addr_top", imem_address, 32'hFFFF_FFFC);
    tick_neg();
    chk("wrap_addr_zero", imem_address, 32'h0000_0000);
    drain("wrap");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_redirect();
    test_stall();
    test_redirect_resp_stall();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. It consumes the PC-select decision (pcmux_sel) and the downstream stall produced by the hazard unit.
- Owns the PC and drives the instruction-memory request port.
- Delivers {pc, instr, valid} into the IF/ID boundary.
- Absorbs variable imem latency and squashes in-flight fetches made stale by a taken branch/jump.

Parameters:
RESET_PC, 32'h0000_0060, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
pcmux_sel  in  pcmux_sel_t  pc_plus4 = sequential; alu_out = redirect to br_target this cycle
br_target  in  32  redirect target from EX, sampled only when pcmux_sel==alu_out
stall  in  1  IF/ID register must hold (IFID_en low)
imem_read  out  1  fetch request; held until imem_resp
imem_address  out  32  fetch address; stable while imem_read high
imem_rdata  in  32  instruction word, valid with imem_resp
imem_resp  in  1  one-cycle response strobe; may arrive in the same cycle as imem_read rises
if_valid  out  1  if_pc/if_instr hold a live instruction
if_pc  out  32  PC of delivered instruction
if_instr  out  32  delivered instruction
fetch_busy  out  1  request outstanding, no response this cycle (hazard unit stalls younger stages)

Behaviour:
Reset (rst low, asynchronous):
- pc_q=RESET_PC, state=FETCH, kill=0, skid_valid=0.
- if_valid=0, if_pc=0, if_instr=0.
- imem_read may assert combinationally from FETCH immediately after reset deasserts.

State machine:
- FETCH:
  - imem_read=1, imem_address=pc_q.
  - fetch_busy = imem_read & ~imem_resp.
- HOLD:
  - imem_read=0; a fetched word waits in the skid register {skid_pc, skid_instr}.

Per-cycle priority, highest first:
1. Redirect (pcmux_sel==alu_out):
   - pc_q<=br_target; if_valid<=0; skid_valid<=0; state<=FETCH.
   - If state==FETCH and imem_resp==0, set kill<=1. The outstanding request completes at its old address and its response is discarded.
   - If imem_resp==1 this cycle, the response is discarded and kill stays 0.
   - Redirect overrides stall.
2. FETCH with imem_resp and kill==1:
   - Discard the data; kill<=0; pc_q unchanged; the new request issues next cycle.
3. FETCH with imem_resp, kill==0:
   - If stall==0 or if_valid==0: load if_pc<=pc_q, if_instr<=imem_rdata, if_valid<=1; pc_q<=pc_q+4.
   - Otherwise: skid<={pc_q, imem_rdata}, skid_valid<=1; pc_q<=pc_q+4; state<=HOLD.
4. HOLD with stall==0:
   - Move skid to the if_* outputs, if_valid<=1, skid_valid<=0, state<=FETCH.
5. No new word and stall==0:
   - if_valid<=0 (bubble). if_pc/if_instr may retain stale values.
6. stall==1:
   - if_* outputs hold.

Arithmetic and timing:
- PC arithmetic is 32-bit, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- br_target low bits are not checked.
- Zero-wait memory gives 1 instr/cycle throughput.
- Latency is response edge -> if_valid on the next edge.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetch_cnt[31:0] (responses accepted), perf_squash_cnt[31:0] (responses discarded via kill or same-cycle redirect), and perf_stall_cnt[31:0] (cycles with fetch_busy=1). All reset to 0, wrap at 2^32.
- Undefined: those ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package rv32i_types:
  - fetch_state_t enum {FETCH, HOLD}
  - if_packet_t struct {valid, pc, instr}
  - the default constant RESET_PC_DEFAULT=32'h60
- pcmux_sel_t stays in rv32i_mux_types.
- One sub-module, fetch_skid_buffer: 1-entry {pc, instr} holding register with load/unload/clear. The FSM and PC stay in fetch_unit.

Test Plan:
- Reset with zero-wait memory returning addr-as-data -> if_pc = 0x60, 0x64, 0x68 on consecutive cycles, if_valid=1 from the 2nd edge after release.
- 3-cycle memory latency -> imem_address held at 0x60 for 3 cycles, fetch_busy=1 for 2 cycles, then if_instr=rdata, next request at 0x64.
- Redirect to 0x200 while a 0x64 request waits 2 more cycles -> 0x64 response discarded (if_valid stays 0), next imem_address=0x200, first delivered if_pc=0x200.
- stall=1 for 4 cycles while if_valid=1 (0x60) and zero-wait memory -> 0x64 captured in skid, imem_read=0 in HOLD. Outputs stay 0x60. On release, 0x64 then 0x68 appear, nothing lost or duplicated.
- Redirect asserted same cycle as imem_resp and stall=1 -> response dropped, skid cleared, if_valid=0 next cycle, pc_q=br_target.
- pc_q=0xFFFFFFFC sequential fetch -> next imem_address=0x00000000. With FETCH_PERF_EN, perf_squash_cnt increments exactly once per discarded response.
